// File: rtl/uart_core_arbiter_if.sv
// Signal bundle between the two CPU cores, the core arbiter and the UART register file.
// slave is the arbiter's view; master is the cores/UART environment's view.
interface uart_core_arbiter_if;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] wdata0, wdata1;
  logic        lock0, lock1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic        owner;
  logic        lock_lost;
  logic        uart_tx_write, uart_rx_read, uart_sr_read;
  logic [31:0] uart_cr, uart_tdr;
  logic [31:0] uart_rdr, uart_sr;
  logic [2:0]  fsm_state;

  modport slave (
    input  req0, req1, op0, op1, wdata0, wdata1, lock0, lock1, uart_rdr, uart_sr,
    output ack0, ack1, rdata, owner, lock_lost, uart_tx_write, uart_rx_read,
           uart_sr_read, uart_cr, uart_tdr, fsm_state
  );

  modport master (
    output req0, req1, op0, op1, wdata0, wdata1, lock0, lock1, uart_rdr, uart_sr,
    input  ack0, ack1, rdata, owner, lock_lost, uart_tx_write, uart_rx_read,
           uart_sr_read, uart_cr, uart_tdr, fsm_state
  );
endinterface

// File: rtl/uart_core_arbiter.sv
// Round-robin arbiter (with optional ownership lock) sharing one UART register interface
// between two cores; shapes UART strobes and owns the cr/tdr registers.
module uart_core_arbiter #(
  parameter int STROBE_W     = 2,
  parameter int SETTLE_W     = 3,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic                clk,
  input logic                rst_n,
  uart_core_arbiter_if.slave bus
);

  // Handshake: a core raises reqN with opN/wdataN/lockN stable and holds them until its
  // one-cycle ackN; there is no other flow control and the UART side never stalls.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_STROBE = 3'd2,
    S_SETTLE = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam logic [3:0]  STROBE_LAST  = 4'(STROBE_W - 1);
  localparam logic [3:0]  SETTLE_LAST  = 4'(SETTLE_W - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]  OP_TDR = 2'b00;
  localparam logic [1:0]  OP_RDR = 2'b01;
  localparam logic [1:0]  OP_SR  = 2'b10;
  localparam logic [1:0]  OP_CR  = 2'b11;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [15:0] idle_cnt;
  logic        owner_q, last_grant, locked, lock_q;
  logic [1:0]  op_q;
  logic [31:0] rdata_q, cr_q, tdr_q;

  logic        owner_req, other_req, cur_lock;
  logic [1:0]  cur_op;
  logic [31:0] cur_wdata;
  logic        grant_any, grant_core, timeout_hit;

  always_comb begin
    owner_req = owner_q ? bus.req1   : bus.req0;
    other_req = owner_q ? bus.req0   : bus.req1;
    cur_op    = owner_q ? bus.op1    : bus.op0;
    cur_wdata = owner_q ? bus.wdata1 : bus.wdata0;
    cur_lock  = owner_q ? bus.lock1  : bus.lock0;
  end

  always_comb begin
    grant_any  = 1'b0;
    grant_core = owner_q;
    if (locked) begin
      grant_any = owner_req;
    end else if (bus.req0 && bus.req1) begin
      grant_any  = 1'b1;
      grant_core = ~last_grant;
    end else if (bus.req0) begin
      grant_any  = 1'b1;
      grant_core = 1'b0;
    end else if (bus.req1) begin
      grant_any  = 1'b1;
      grant_core = 1'b1;
    end
  end

  assign timeout_hit = (state == S_IDLE) && locked && !owner_req && (idle_cnt == TIMEOUT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (grant_any) state_nx = S_GRANT;
      S_GRANT:  state_nx = S_STROBE;
      S_STROBE: if (cnt == 4'd0) state_nx = S_SETTLE;
      S_SETTLE: if (cnt == 4'd0) state_nx = S_ACK;
      // The finishing owner still holds req during ACK, so only the other core may be
      // granted straight away, and only when no lock is about to be taken.
      S_ACK:    state_nx = (!lock_q && other_req) ? S_GRANT : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idle_cnt   <= '0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      locked     <= 1'b0;
      lock_q     <= 1'b0;
      op_q       <= OP_TDR;
      rdata_q    <= '0;
      cr_q       <= '0;
      tdr_q      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (grant_any) owner_q <= grant_core;
          if (locked && !grant_any) begin
            if (timeout_hit) begin
              locked   <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        S_GRANT: begin
          op_q       <= cur_op;
          lock_q     <= cur_lock;
          last_grant <= owner_q;
          cnt        <= STROBE_LAST;
          if (cur_op == OP_TDR) tdr_q <= cur_wdata;
          if (cur_op == OP_CR)  cr_q  <= cur_wdata;
        end
        S_STROBE: begin
          // Sample in the first strobe cycle; the UART pops its FIFO only after the falling edge.
          if (cnt == STROBE_LAST) begin
            if (op_q == OP_RDR)     rdata_q <= bus.uart_rdr;
            else if (op_q == OP_SR) rdata_q <= bus.uart_sr;
          end
          cnt <= (cnt == 4'd0) ? SETTLE_LAST : cnt - 4'd1;
        end
        S_SETTLE: cnt <= cnt - 4'd1;
        S_ACK: begin
          locked   <= lock_q;
          idle_cnt <= '0;
          if (state_nx == S_GRANT) owner_q <= ~owner_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.uart_tx_write = (state == S_STROBE) && (op_q == OP_TDR);
  assign bus.uart_rx_read  = (state == S_STROBE) && (op_q == OP_RDR);
  assign bus.uart_sr_read  = (state == S_STROBE) && (op_q == OP_SR);
  assign bus.ack0          = (state == S_ACK) && !owner_q;
  assign bus.ack1          = (state == S_ACK) &&  owner_q;
  assign bus.rdata         = rdata_q;
  assign bus.owner         = owner_q;
  assign bus.lock_lost     = timeout_hit;
  assign bus.uart_cr       = cr_q;
  assign bus.uart_tdr      = tdr_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_uart_core_arbiter.sv
// Directed bench for uart_core_arbiter: drivers push expected acks into a queue, a negedge
// monitor pops and compares them; cycle-exact checks cover latency, locking and reset.
module tb_uart_core_arbiter;
  localparam int STROBE_W     = 2;
  localparam int SETTLE_W     = 3;
  localparam int LOCK_TIMEOUT = 1024;
  localparam int ACK_LIMIT    = 3000;

  logic clk;
  logic rst_n;
  uart_core_arbiter_if bus();

  uart_core_arbiter #(
    .STROBE_W    (STROBE_W),
    .SETTLE_W    (SETTLE_W),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // {check_rdata, core, rdata}
  logic [33:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit chk_rd, input bit core, input logic [31:0] rd);
    exp_q.push_back({chk_rd, core, rd});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input bit core, input logic [1:0] op, input logic [31:0] wd,
                        input bit lk, output int ack_cyc);
    bit seen;
    seen = 1'b0;
    if (core) begin
      bus.op1 = op; bus.wdata1 = wd; bus.lock1 = lk; bus.req1 = 1'b1;
    end else begin
      bus.op0 = op; bus.wdata0 = wd; bus.lock0 = lk; bus.req0 = 1'b1;
    end
    for (int n = 0; n < ACK_LIMIT && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = core ? bus.ack1 : bus.ack0;
    end
    ack_cyc = cyc;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: core%0d got no ack, want ack within %0d cycles", core, ACK_LIMIT);
    end
    if (core) begin
      bus.req1 = 1'b0; bus.lock1 = 1'b0;
    end else begin
      bus.req0 = 1'b0; bus.lock0 = 1'b0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [33:0] mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (bus.ack0 || bus.ack1)) begin
        if (bus.ack0 && bus.ack1) begin
          total++;
          bad++;
          $display("FAIL ack_onehot: got ack0=1 ack1=1, want one ack");
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, want none", bus.ack0, bus.ack1);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_core", 32'(bus.ack1), 32'(mon_e[32]));
          if (mon_e[33]) check("ack_rdata", bus.rdata, mon_e[31:0]);
        end
      end
    end
  end

  // Strobe spacing: every rising strobe must follow at least SETTLE_W low cycles.
  logic strobe_prev;
  logic any_s;
  int   low_run;
  bit   seen_strobe;
  initial begin
    strobe_prev = 1'b0;
    low_run     = 0;
    seen_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        strobe_prev = 1'b0;
        low_run     = 0;
        seen_strobe = 1'b0;
      end else begin
        any_s = bus.uart_tx_write | bus.uart_rx_read | bus.uart_sr_read;
        if (any_s && !strobe_prev && seen_strobe) begin
          total++;
          if (low_run < SETTLE_W) begin
            bad++;
            $display("FAIL strobe_gap: got %0d low cycles, want >= %0d", low_run, SETTLE_W);
          end
        end
        if (any_s) begin
          seen_strobe = 1'b1;
          low_run     = 0;
        end else begin
          low_run++;
        end
        strobe_prev = any_s;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  c0, c1, ca, ll_cyc, ll_count, n;
    bit  any_ack, tx_seen;

    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.uart_rdr = 0; bus.uart_sr = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_strobes", 32'({bus.uart_tx_write, bus.uart_rx_read, bus.uart_sr_read}), 32'd0);
    check("rst_acks", 32'({bus.ack0, bus.ack1, bus.lock_lost}), 32'd0);
    check("rst_cr", bus.uart_cr, 32'd0);
    check("rst_tdr", bus.uart_tdr, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single TDR write, cycle-exact
    push_exp(1'b0, 1'b0, 32'h0);
    bus.op0 = 2'b00; bus.wdata0 = 32'h41; bus.req0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) check("t1_tdr_c2", bus.uart_tdr, 32'h41);
      check($sformatf("t1_tx_write_c%0d", k), 32'(bus.uart_tx_write), 32'(k == 2 || k == 3));
      check($sformatf("t1_ack0_c%0d", k), 32'(bus.ack0), 32'(k == 7));
    end
    bus.req0 = 1'b0;
    idle(1);

    // Contention after fresh reset: core0 first, core1 seven cycles later
    do_reset();
    bus.uart_sr = 32'h0000_1234;
    push_exp(1'b1, 1'b0, 32'h0000_1234);
    push_exp(1'b1, 1'b1, 32'h0000_1234);
    fork
      do_txn(1'b0, 2'b10, 32'h0, 1'b0, c0);
      do_txn(1'b1, 2'b10, 32'h0, 1'b0, c1);
    join
    check("t2_ack_spacing", 32'(c1 - c0), 32'd7);
    idle(1);

    // Lock hold: core1 keeps ownership even though core0 is next in rotation
    push_exp(1'b0, 1'b1, 32'h0);
    do_txn(1'b1, 2'b11, 32'h0A03_0001, 1'b1, c1);
    check("t3_cr", bus.uart_cr, 32'h0A03_0001);
    idle(1);
    push_exp(1'b1, 1'b1, 32'h0000_1234);
    push_exp(1'b0, 1'b0, 32'h0);
    fork
      do_txn(1'b1, 2'b10, 32'h0, 1'b0, c1);
      do_txn(1'b0, 2'b00, 32'h99, 1'b0, c0);
    join
    check("t3_ack_spacing", 32'(c0 - c1), 32'd7);
    check("t3_tdr", bus.uart_tdr, 32'h99);
    idle(1);

    // RDR read ordering: FIFO head changes two cycles after the rx_read falling edge
    bus.uart_rdr = 32'h55;
    push_exp(1'b1, 1'b0, 32'h55);
    fork
      do_txn(1'b0, 2'b01, 32'h0, 1'b0, c0);
      begin
        n = 0;
        while (!bus.uart_rx_read && n < 20) begin @(posedge clk); #1; n++; end
        while (bus.uart_rx_read && n < 40) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        bus.uart_rdr = 32'h66;
      end
    join
    idle(1);
    push_exp(1'b1, 1'b1, 32'h66);
    do_txn(1'b1, 2'b01, 32'h0, 1'b0, c1);
    idle(1);

    // Lock timeout
    bus.uart_sr = 32'h0000_0A5A;
    push_exp(1'b1, 1'b0, 32'h0000_0A5A);
    do_txn(1'b0, 2'b10, 32'h0, 1'b1, ca);
    idle(10);
    push_exp(1'b1, 1'b1, 32'h0000_0A5A);
    ll_cyc   = -1;
    ll_count = 0;
    fork
      do_txn(1'b1, 2'b10, 32'h0, 1'b0, c1);
      begin
        for (int i = 0; i < LOCK_TIMEOUT + 100; i++) begin
          @(posedge clk);
          #1;
          if (bus.lock_lost) begin
            ll_count++;
            if (ll_cyc < 0) ll_cyc = cyc;
          end
          if (ll_cyc >= 0 && cyc == ll_cyc + 1) check("t5_owner_held", 32'(bus.owner), 32'd0);
          if (ll_cyc >= 0 && cyc == ll_cyc + 2) check("t5_owner_granted", 32'(bus.owner), 32'd1);
        end
      end
    join
    check("t5_lock_lost_delay", 32'(ll_cyc - ca), 32'(LOCK_TIMEOUT));
    check("t5_lock_lost_pulses", 32'(ll_count), 32'd1);
    check("t5_ack1_delay", 32'(c1 - ca), 32'(LOCK_TIMEOUT + 8));
    idle(1);

    // Reset in the middle of a tx_write strobe
    bus.op0 = 2'b00; bus.wdata0 = 32'h77; bus.req0 = 1'b1;
    tx_seen = 1'b0;
    for (int i = 0; i < 20 && !tx_seen; i++) begin
      @(posedge clk);
      #1;
      tx_seen = bus.uart_tx_write;
    end
    check("t6_tx_reached", 32'(tx_seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_strobes_low", 32'({bus.uart_tx_write, bus.uart_rx_read, bus.uart_sr_read}), 32'd0);
    check("t6_cr_cleared", bus.uart_cr, 32'd0);
    check("t6_tdr_cleared", bus.uart_tdr, 32'd0);
    check("t6_owner_cleared", 32'(bus.owner), 32'd0);
    bus.req0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      any_ack = any_ack | bus.ack0 | bus.ack1;
    end
    check("t6_no_ack_after_abort", 32'(any_ack), 32'd0);
    push_exp(1'b1, 1'b0, 32'h0000_0A5A);
    push_exp(1'b0, 1'b1, 32'h0);
    fork
      do_txn(1'b0, 2'b10, 32'h0, 1'b0, c0);
      do_txn(1'b1, 2'b00, 32'h88, 1'b0, c1);
    join
    check("t6_ack_spacing", 32'(c1 - c0), 32'd7);
    check("t6_tdr", bus.uart_tdr, 32'h88);

    idle(5);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
